// File: rtl/led_link_pkg.sv
// rtl/led_link_pkg.sv - shared types and default timing for the LED nibble link
package led_link_pkg;

  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  localparam int unsigned SETTLE    = 16;
  localparam int unsigned PHASE_MIN = 20_000_000;
  localparam int unsigned PHASE_MAX = 30_000_000;
  localparam int unsigned NUM       = 25_000_000;
  localparam int unsigned ALL       = 50_000_000;

  // Nibbles travel active-low: a driven-low led line is a logic 1 bit.
  localparam logic [3:0] NIB_DARK = 4'hF;

  function automatic logic [3:0] nib_value(input logic [3:0] raw);
    return ~raw;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with parameterised width and reset value
module sync2 #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/led_rx.sv
// rtl/led_rx.sv - LED nibble link receiver: sync, phase timing check, byte rebuild
module led_rx #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned SETTLE    = led_link_pkg::SETTLE,
  parameter int unsigned PHASE_MIN = led_link_pkg::PHASE_MIN,
  parameter int unsigned PHASE_MAX = led_link_pkg::PHASE_MAX
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       lec_in,
  input  logic [3:0] led_in,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       locked
);
  import led_link_pkg::*;

  localparam logic [CNT_W-1:0] C_SETTLE = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] C_MIN    = CNT_W'(PHASE_MIN);
  localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(PHASE_MAX);
  localparam logic [CNT_W-1:0] C_TOUT   = CNT_W'(PHASE_MAX + 1);

  logic             lec_s, lec_d;
  logic [3:0]       led_s;
  logic             fall, rise, lec_edge;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       nib;
  logic             cap;
  logic             stab_err, len_ok, tout, bad;

  state_t     state, state_nxt;
  logic [3:0] hi_nib, hi_nib_nxt;
  logic [7:0] data_nxt;
  logic       dv_nxt, err_nxt, locked_nxt;

  sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_lec (
    .clk(sys_clk), .rst_n(rst_n), .d(lec_in), .q(lec_s)
  );

  sync2 #(.W(4), .RST_VAL(NIB_DARK)) u_sync_led (
    .clk(sys_clk), .rst_n(rst_n), .d(led_in), .q(led_s)
  );

  assign fall     = lec_d & ~lec_s;
  assign rise     = ~lec_d & lec_s;
  assign lec_edge = fall | rise;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      lec_d <= 1'b1;
      cnt   <= '0;
      nib   <= NIB_DARK;
      cap   <= 1'b0;
    end else begin
      lec_d <= lec_s;
      if (lec_edge) begin
        cnt <= CNT_W'(1);
        cap <= 1'b0;
      end else begin
        if (cnt != C_TOUT) cnt <= cnt + 1'b1;
        if (cnt == C_SETTLE) begin
          nib <= led_s;
          cap <= 1'b1;
        end
      end
    end
  end

  // The edge cycle already carries the next phase's nibble, so it is not checked.
  assign stab_err = cap & ~lec_edge & (led_s != nib);
  assign len_ok   = (cnt >= C_MIN) && (cnt <= C_MAX);
  assign tout     = (cnt == C_TOUT);
  assign bad      = stab_err | tout | (lec_edge & ~len_ok);

  always_comb begin
    state_nxt  = state;
    hi_nib_nxt = hi_nib;
    data_nxt   = data;
    dv_nxt     = 1'b0;
    err_nxt    = 1'b0;
    locked_nxt = locked;
    case (state)
      IDLE: if (fall) state_nxt = HI;
      HI: begin
        if (bad) begin
          err_nxt = 1'b1;
        end else if (rise) begin
          hi_nib_nxt = nib_value(nib);
          state_nxt  = LO;
        end
      end
      LO: begin
        if (bad) begin
          err_nxt = 1'b1;
        end else if (fall) begin
          data_nxt   = {hi_nib, nib_value(nib)};
          dv_nxt     = 1'b1;
          locked_nxt = 1'b1;
          state_nxt  = HI;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (err_nxt) begin
      state_nxt  = IDLE;
      locked_nxt = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hi_nib     <= 4'h0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_nxt;
      hi_nib     <= hi_nib_nxt;
      data       <= data_nxt;
      data_valid <= dv_nxt;
      frame_err  <= err_nxt;
      locked     <= locked_nxt;
    end
  end

endmodule
